// File: rtl/spi_flash_pkg.sv
// spi_flash_pkg
// Shared types and constants for the SPI NOR flash reader.
//   state_t        - controller states (IDLE, SHIFT, RESP, GAP)
//   FLASH_CMD_READ - serial flash READ opcode (03h)
//   TX_BITS        - command + address bits shifted out
//   RX_BITS        - data bits shifted in
//   SPI_BITS       - total sck periods in one transaction
//   byte_swap32    - reorders the MSB-first received stream into a
//                    little-endian word (first byte received lands in [7:0])
package spi_flash_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        RESP,
        GAP
    } state_t;

    localparam logic [7:0] FLASH_CMD_READ = 8'h03;
    localparam int         TX_BITS        = 32;
    localparam int         RX_BITS        = 32;
    localparam int         SPI_BITS       = 64;

    function automatic logic [31:0] byte_swap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/spi_clkgen.sv
// spi_clkgen
// Generates the SPI mode-0 serial clock from the system clock.
// Ports:
//   clock  in  - system clock
//   resetn in  - synchronous active-low reset
//   en     in  - run the serial clock; when low, sck is parked low and the
//                half-period counter is cleared
//   sck    out - serial clock, idles low
//   rise   out - high in the cycle whose closing edge drives sck 0->1
//   fall   out - high in the cycle whose closing edge drives sck 1->0
module spi_clkgen import spi_flash_pkg::*; #(
    parameter int DIV = 2
) (
    input  logic clock,
    input  logic resetn,
    input  logic en,
    output logic sck,
    output logic rise,
    output logic fall
);

    localparam int            CW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          sck_q, sck_d;
    logic          tick;

    // The counter spans one sck half-period; on its last count sck toggles.
    // rise/fall are combinational so the controller can shift data on the
    // very same edge that moves sck.
    always_comb begin
        cnt_d = cnt_q;
        sck_d = sck_q;
        tick  = en && (cnt_q == CNT_MAX);
        rise  = tick && !sck_q;
        fall  = tick && sck_q;
        if (!en) begin
            cnt_d = '0;
            sck_d = 1'b0;
        end else if (tick) begin
            cnt_d = '0;
            sck_d = ~sck_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            cnt_q <= '0;
            sck_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sck_q <= sck_d;
        end
    end

    assign sck = sck_q;

endmodule

// File: rtl/spi_flash_reader.sv
// spi_flash_reader
// SPI mode-0 master issuing single 32-bit READ (03h) transactions to a
// serial NOR flash and returning the data on a valid/ready port.
// Ports:
//   clock, resetn            - system clock, synchronous active-low reset
//   req_valid/req_ready      - read request handshake
//   req_addr[23:0]           - byte address, low two bits forced to zero
//   resp_valid/resp_ready    - response handshake
//   resp_data[31:0]          - little-endian word read from the flash
//   sck, ss, mosi, miso      - flash serial bus
module spi_flash_reader import spi_flash_pkg::*; #(
    parameter int DIV    = 2,
    parameter int CS_GAP = 4
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [23:0] req_addr,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic        sck,
    output logic        ss,
    output logic        mosi,
    input  logic        miso
);

    localparam int            GW       = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(CS_GAP - 1);
    localparam logic [6:0]    TX_CNT   = 7'(TX_BITS);
    localparam logic [6:0]    SPI_CNT  = 7'(SPI_BITS);

    state_t               state_q, state_d;
    logic [TX_BITS-1:0]   tx_q, tx_d;
    logic [RX_BITS-1:0]   rx_q, rx_d;
    logic [6:0]           bit_cnt_q, bit_cnt_d;
    logic [GW-1:0]        gap_cnt_q, gap_cnt_d;
    logic [31:0]          resp_data_q, resp_data_d;
    logic                 sck_rise, sck_fall;
    logic                 unused_addr_lsbs;

    assign unused_addr_lsbs = ^req_addr[1:0];

    spi_clkgen #(.DIV(DIV)) u_clkgen (
        .clock  (clock),
        .resetn (resetn),
        .en     (state_q == SHIFT),
        .sck    (sck),
        .rise   (sck_rise),
        .fall   (sck_fall)
    );

    // bit_cnt_q counts sck rising edges already issued. Data is captured on
    // rises 33..64 and mosi advances on every fall; zeros shifted into tx
    // keep mosi low once command and address are out. The transaction ends
    // on the 64th fall, which is also where the response word is frozen.
    always_comb begin
        state_d     = state_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        bit_cnt_d   = bit_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        resp_data_d = resp_data_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    tx_d      = {FLASH_CMD_READ, req_addr[23:2], 2'b00};
                    rx_d      = '0;
                    bit_cnt_d = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (sck_rise) begin
                    bit_cnt_d = bit_cnt_q + 7'd1;
                    if (bit_cnt_q >= TX_CNT) begin
                        rx_d = {rx_q[RX_BITS-2:0], miso};
                    end
                end
                if (sck_fall) begin
                    tx_d = {tx_q[TX_BITS-2:0], 1'b0};
                    if (bit_cnt_q == SPI_CNT) begin
                        resp_data_d = byte_swap32(rx_q);
                        state_d     = RESP;
                    end
                end
            end
            RESP: begin
                if (resp_ready) begin
                    gap_cnt_d = '0;
                    state_d   = GAP;
                end
            end
            GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q     <= IDLE;
            tx_q        <= '0;
            rx_q        <= '0;
            bit_cnt_q   <= '0;
            gap_cnt_q   <= '0;
            resp_data_q <= '0;
        end else begin
            state_q     <= state_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            bit_cnt_q   <= bit_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            resp_data_q <= resp_data_d;
        end
    end

    // req_ready is qualified by resetn so no request is offered while the
    // block is being held in reset.
    assign req_ready  = resetn && (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_data  = resp_data_q;
    assign ss         = (state_q != SHIFT);
    assign mosi       = (state_q == SHIFT) && tx_q[TX_BITS-1];

endmodule

// File: tb/tb_spi_flash_reader.sv
// tb_spi_flash_reader
// Self-checking bench for spi_flash_reader. Two instances (DIV=2 and DIV=1)
// share one behavioural flash model through a select mux; expected words are
// assembled byte by byte from the model memory.
module tb_spi_flash_reader;

    localparam int DIV0 = 2;
    localparam int GAP0 = 4;
    localparam int DIV1 = 1;
    localparam int GAP1 = 2;

    logic        clock      = 1'b0;
    logic        resetn     = 1'b0;
    logic        req_valid  = 1'b0;
    logic        resp_ready = 1'b0;
    logic        sel        = 1'b0;
    logic        miso       = 1'b0;
    logic [23:0] req_addr   = '0;

    logic        req_ready0, resp_valid0, sck0, ss0, mosi0;
    logic        req_ready1, resp_valid1, sck1, ss1, mosi1;
    logic [31:0] resp_data0, resp_data1;
    logic        req_valid0, req_valid1;

    logic        req_ready_m, resp_valid_m, sck_m, ss_m, mosi_m;
    logic [31:0] resp_data_m;
    int          cur_div;

    always #5 clock = ~clock;

    assign req_valid0   = req_valid && !sel;
    assign req_valid1   = req_valid && sel;
    assign req_ready_m  = sel ? req_ready1  : req_ready0;
    assign resp_valid_m = sel ? resp_valid1 : resp_valid0;
    assign resp_data_m  = sel ? resp_data1  : resp_data0;
    assign sck_m        = sel ? sck1        : sck0;
    assign ss_m         = sel ? ss1         : ss0;
    assign mosi_m       = sel ? mosi1       : mosi0;
    assign cur_div      = sel ? DIV1        : DIV0;

    spi_flash_reader #(.DIV(DIV0), .CS_GAP(GAP0)) dut (
        .clock(clock), .resetn(resetn),
        .req_valid(req_valid0), .req_ready(req_ready0), .req_addr(req_addr),
        .resp_valid(resp_valid0), .resp_ready(resp_ready), .resp_data(resp_data0),
        .sck(sck0), .ss(ss0), .mosi(mosi0), .miso(miso)
    );

    spi_flash_reader #(.DIV(DIV1), .CS_GAP(GAP1)) dut1 (
        .clock(clock), .resetn(resetn),
        .req_valid(req_valid1), .req_ready(req_ready1), .req_addr(req_addr),
        .resp_valid(resp_valid1), .resp_ready(resp_ready), .resp_data(resp_data1),
        .sck(sck1), .ss(ss1), .mosi(mosi1), .miso(miso)
    );

    int cyc   = 0;
    int total = 0;
    int bad   = 0;

    always @(posedge clock) cyc <= cyc + 1;

    // Flash contents: explicit bytes in mem, a fixed pattern elsewhere.
    logic [7:0] mem [int];

    function automatic logic [7:0] flash_byte(input logic [23:0] a);
        if (mem.exists(int'(a))) return mem[int'(a)];
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'hA5;
    endfunction

    function automatic logic slave_bit(input logic [23:0] base, input int j);
        logic [7:0] b;
        b = flash_byte(base + 24'(j / 8));
        return b[7 - (j % 8)];
    endfunction

    function automatic logic [31:0] expect_word(input logic [23:0] a);
        logic [23:0] al;
        al = {a[23:2], 2'b00};
        return {flash_byte(al + 24'd3), flash_byte(al + 24'd2),
                flash_byte(al + 24'd1), flash_byte(al)};
    endfunction

    // Flash slave and bus monitor, evaluated on the falling system clock edge
    // so every DUT output has settled.
    logic        prev_sck = 1'b0, prev_ss = 1'b1, prev_mosi = 1'b0;
    int          rise_cnt = 0, last_rise = 0, period_bad = 0, mosi_bad = 0;
    int          ss_rise_cyc = 0, ss_fall_cyc = 0, sl_bits = 0;
    logic [30:0] sl_in   = '0;
    logic [7:0]  sl_cmd  = '0;
    logic [23:0] sl_addr = '0;

    always @(negedge clock) begin
        if (ss_m && !prev_ss) ss_rise_cyc <= cyc;
        if (ss_m) begin
            sl_bits <= 0;
            miso    <= 1'b0;
        end else if (prev_ss) begin
            ss_fall_cyc <= cyc;
            rise_cnt    <= 0;
            sl_bits     <= 0;
            period_bad  <= 0;
            mosi_bad    <= 0;
        end else begin
            if (sck_m && !prev_sck) begin
                if (rise_cnt > 0 && (cyc - last_rise) != 2 * cur_div) period_bad <= period_bad + 1;
                last_rise <= cyc;
                rise_cnt  <= rise_cnt + 1;
                if (sl_bits < 31) sl_in <= {sl_in[29:0], mosi_m};
                if (sl_bits == 31) begin
                    sl_cmd  <= sl_in[30:23];
                    sl_addr <= {sl_in[22:0], mosi_m};
                end
                sl_bits <= sl_bits + 1;
            end
            if (!sck_m && prev_sck && sl_bits >= 32 && sl_bits < 64)
                miso <= slave_bit(sl_addr, sl_bits - 32);
            if (sck_m && (mosi_m !== prev_mosi)) mosi_bad <= mosi_bad + 1;
        end
        prev_sck  <= sck_m;
        prev_ss   <= ss_m;
        prev_mosi <= mosi_m;
    end

    int hold_data_bad, hold_ready_bad, hold_ss_bad, hold_valid_bad;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // One complete read: request, wait for the response, optionally stall
    // resp_ready for 'hold' cycles, then accept. Returns at cycle R+1.
    task automatic do_read(input logic [23:0] addr, input int hold,
                           output logic [31:0] data, output int lat, output bit ok);
        int t;
        ok = 0; lat = 0; data = '0; t = 0;
        hold_data_bad = 0; hold_ready_bad = 0; hold_ss_bad = 0; hold_valid_bad = 0;
        req_addr  = addr;
        req_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (req_ready_m) begin t = cyc; ok = 1; break; end
            step();
        end
        if (!ok) begin req_valid = 1'b0; return; end
        step();
        req_valid = 1'b0;
        ok = 0;
        for (int i = 0; i < 2000; i++) begin
            if (resp_valid_m) begin ok = 1; break; end
            step();
        end
        if (!ok) return;
        lat  = cyc - t;
        data = resp_data_m;
        for (int i = 0; i < hold; i++) begin
            step();
            if (resp_data_m !== data) hold_data_bad++;
            if (req_ready_m !== 1'b0) hold_ready_bad++;
            if (ss_m !== 1'b1) hold_ss_bad++;
            if (resp_valid_m !== 1'b1) hold_valid_bad++;
        end
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        $display("[TB] test_reset");
        resetn = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
        repeat (3) step();
        total++; if (req_ready_m !== 1'b0) begin bad++; $display("[TB] FAIL reset_req_ready: observed=%b expected=0", req_ready_m); end
        total++; if (resp_valid_m !== 1'b0) begin bad++; $display("[TB] FAIL reset_resp_valid: observed=%b expected=0", resp_valid_m); end
        total++; if (resp_data_m !== 32'h0) begin bad++; $display("[TB] FAIL reset_resp_data: observed=%h expected=0", resp_data_m); end
        total++; if (sck_m !== 1'b0) begin bad++; $display("[TB] FAIL reset_sck: observed=%b expected=0", sck_m); end
        total++; if (ss_m !== 1'b1) begin bad++; $display("[TB] FAIL reset_ss: observed=%b expected=1", ss_m); end
        total++; if (mosi_m !== 1'b0) begin bad++; $display("[TB] FAIL reset_mosi: observed=%b expected=0", mosi_m); end
        resetn = 1'b1;
        step();
        total++; if (req_ready_m !== 1'b1) begin bad++; $display("[TB] FAIL post_reset_req_ready: observed=%b expected=1", req_ready_m); end
    endtask

    task automatic test_basic();
        logic [31:0] d; int lat; bit ok;
        $display("[TB] test_basic");
        do_read(24'h000100, 0, d, lat, ok);
        total++; if (!ok) begin bad++; $display("[TB] FAIL basic_timeout: observed=0 expected=1"); end
        total++; if (sl_cmd !== 8'h03) begin bad++; $display("[TB] FAIL basic_cmd: observed=%h expected=03", sl_cmd); end
        total++; if (sl_addr !== 24'h000100) begin bad++; $display("[TB] FAIL basic_addr: observed=%h expected=000100", sl_addr); end
        total++; if (d !== 32'h44332211) begin bad++; $display("[TB] FAIL basic_data: observed=%h expected=44332211", d); end
        total++; if (lat !== 1 + 128 * DIV0) begin bad++; $display("[TB] FAIL basic_latency: observed=%0d expected=%0d", lat, 1 + 128 * DIV0); end
        total++; if (rise_cnt !== 64) begin bad++; $display("[TB] FAIL basic_sck_rises: observed=%0d expected=64", rise_cnt); end
        total++; if (period_bad !== 0) begin bad++; $display("[TB] FAIL basic_sck_period: observed=%0d expected=0", period_bad); end
        total++; if (mosi_bad !== 0) begin bad++; $display("[TB] FAIL basic_mosi_while_sck_high: observed=%0d expected=0", mosi_bad); end
    endtask

    task automatic test_unaligned();
        logic [31:0] d; int lat; bit ok;
        $display("[TB] test_unaligned");
        do_read(24'h000103, 0, d, lat, ok);
        total++; if (sl_addr !== 24'h000100) begin bad++; $display("[TB] FAIL unaligned_addr: observed=%h expected=000100", sl_addr); end
        total++; if (d !== 32'h44332211) begin bad++; $display("[TB] FAIL unaligned_data: observed=%h expected=44332211", d); end
    endtask

    task automatic test_random();
        logic [31:0] d; int lat; bit ok; logic [23:0] a;
        $display("[TB] test_random");
        for (int n = 0; n < 4; n++) begin
            a = 24'($urandom_range(0, 24'hFFFFFF));
            if (a[23:2] == 22'h40) a = a + 24'h1000;
            for (int b = 0; b < 4; b++) mem[int'({a[23:2], 2'b00}) + b] = 8'($urandom);
            do_read(a, 0, d, lat, ok);
            total++; if (sl_addr !== {a[23:2], 2'b00}) begin bad++; $display("[TB] FAIL random_addr: observed=%h expected=%h", sl_addr, {a[23:2], 2'b00}); end
            total++; if (d !== expect_word(a)) begin bad++; $display("[TB] FAIL random_data: observed=%h expected=%h", d, expect_word(a)); end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] d; int lat; bit ok;
        $display("[TB] test_backpressure");
        do_read(24'h000100, 20, d, lat, ok);
        total++; if (d !== 32'h44332211) begin bad++; $display("[TB] FAIL bp_data: observed=%h expected=44332211", d); end
        total++; if (hold_data_bad !== 0) begin bad++; $display("[TB] FAIL bp_data_stable: observed=%0d expected=0", hold_data_bad); end
        total++; if (hold_ready_bad !== 0) begin bad++; $display("[TB] FAIL bp_req_ready_low: observed=%0d expected=0", hold_ready_bad); end
        total++; if (hold_ss_bad !== 0) begin bad++; $display("[TB] FAIL bp_ss_high: observed=%0d expected=0", hold_ss_bad); end
        total++; if (hold_valid_bad !== 0) begin bad++; $display("[TB] FAIL bp_valid_held: observed=%0d expected=0", hold_valid_bad); end
        total++; if (resp_valid_m !== 1'b0) begin bad++; $display("[TB] FAIL bp_valid_drop: observed=%b expected=0", resp_valid_m); end
        repeat (GAP0 - 1) step();
        total++; if (req_ready_m !== 1'b0) begin bad++; $display("[TB] FAIL gap_not_ready: observed=%b expected=0", req_ready_m); end
        step();
        total++; if (req_ready_m !== 1'b1) begin bad++; $display("[TB] FAIL gap_ready: observed=%b expected=1", req_ready_m); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d0, d1; int r0; bit ok0, ok1;
        $display("[TB] test_back_to_back");
        for (int b = 0; b < 8; b++) mem[b] = 8'($urandom);
        d0 = '0; d1 = '0; r0 = 0; ok0 = 0; ok1 = 0;
        resp_ready = 1'b1;
        req_addr   = 24'h000000;
        req_valid  = 1'b1;
        for (int i = 0; i < 200; i++) begin if (req_ready_m) break; step(); end
        step();
        req_addr = 24'h000004;
        for (int i = 0; i < 2000; i++) begin if (resp_valid_m) begin ok0 = 1; d0 = resp_data_m; break; end step(); end
        step();
        r0 = ss_rise_cyc;
        for (int i = 0; i < 200; i++) begin if (req_ready_m) break; step(); end
        step();
        req_valid = 1'b0;
        for (int i = 0; i < 2000; i++) begin if (resp_valid_m) begin ok1 = 1; d1 = resp_data_m; break; end step(); end
        step();
        resp_ready = 1'b0;
        total++; if (!(ok0 && ok1)) begin bad++; $display("[TB] FAIL b2b_timeout: observed=%b%b expected=11", ok0, ok1); end
        total++; if (d0 !== expect_word(24'h000000)) begin bad++; $display("[TB] FAIL b2b_first_data: observed=%h expected=%h", d0, expect_word(24'h000000)); end
        total++; if (d1 !== expect_word(24'h000004)) begin bad++; $display("[TB] FAIL b2b_second_data: observed=%h expected=%h", d1, expect_word(24'h000004)); end
        total++; if (ss_fall_cyc - r0 < GAP0 + 1) begin bad++; $display("[TB] FAIL b2b_ss_gap: observed=%0d expected>=%0d", ss_fall_cyc - r0, GAP0 + 1); end
    endtask

    task automatic test_reset_mid_shift();
        logic [31:0] d; int lat; bit ok; int k; int seen; logic p;
        $display("[TB] test_reset_mid_shift");
        k = 0; seen = 0; p = 1'b0;
        req_addr = 24'h000100; req_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin if (req_ready_m) break; step(); end
        step();
        req_valid = 1'b0;
        for (int i = 0; i < 1000 && k < 40; i++) begin
            if (sck_m && !p) k++;
            p = sck_m;
            if (k < 40) step();
        end
        total++; if (k !== 40) begin bad++; $display("[TB] FAIL midrst_reach_rise40: observed=%0d expected=40", k); end
        resetn = 1'b0;
        step();
        total++; if (ss_m !== 1'b1) begin bad++; $display("[TB] FAIL midrst_ss: observed=%b expected=1", ss_m); end
        total++; if (sck_m !== 1'b0) begin bad++; $display("[TB] FAIL midrst_sck: observed=%b expected=0", sck_m); end
        total++; if (resp_valid_m !== 1'b0) begin bad++; $display("[TB] FAIL midrst_resp_valid: observed=%b expected=0", resp_valid_m); end
        resetn = 1'b1;
        for (int i = 0; i < 300; i++) begin step(); if (resp_valid_m) seen++; end
        total++; if (seen !== 0) begin bad++; $display("[TB] FAIL midrst_no_resp: observed=%0d expected=0", seen); end
        do_read(24'h000100, 0, d, lat, ok);
        total++; if (d !== 32'h44332211) begin bad++; $display("[TB] FAIL midrst_reread: observed=%h expected=44332211", d); end
    endtask

    task automatic test_div1_top_addr();
        logic [31:0] d; int lat; bit ok;
        $display("[TB] test_div1_top_addr");
        sel = 1'b1;
        step();
        for (int b = 0; b < 4; b++) mem[24'hFFFFFC + b] = 8'($urandom);
        do_read(24'hFFFFFC, 0, d, lat, ok);
        total++; if (d !== expect_word(24'hFFFFFC)) begin bad++; $display("[TB] FAIL div1_data: observed=%h expected=%h", d, expect_word(24'hFFFFFC)); end
        total++; if (sl_addr !== 24'hFFFFFC) begin bad++; $display("[TB] FAIL div1_addr: observed=%h expected=fffffc", sl_addr); end
        total++; if (rise_cnt !== 64) begin bad++; $display("[TB] FAIL div1_sck_rises: observed=%0d expected=64", rise_cnt); end
        total++; if (period_bad !== 0) begin bad++; $display("[TB] FAIL div1_sck_period: observed=%0d expected=0", period_bad); end
        total++; if (lat !== 1 + 128 * DIV1) begin bad++; $display("[TB] FAIL div1_latency: observed=%0d expected=%0d", lat, 1 + 128 * DIV1); end
        sel = 1'b0;
    endtask

    initial begin
        mem[32'h100] = 8'h11;
        mem[32'h101] = 8'h22;
        mem[32'h102] = 8'h33;
        mem[32'h103] = 8'h44;
        test_reset();
        test_basic();
        test_unaligned();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_shift();
        test_div1_top_addr();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed=timeout expected=completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
